control_buffer_pixeles: RTL

Sequencer for the 32-bit-to-8-bit pixel buffer (buffer_pixeles_mem). It fetches a run of image words from memory and pulses the buffer's save strobe. It then drains four pixels per word to the downstream filter stage through a valid/ready handshake. Fetch and drain overlap: the controller prefetches into free buffer word slots while pixels stream out.

---
 rtl/ctrl_buf_pkg.sv | 19 +
 rtl/fetch_palabras_mem.sv | 88 ++++++++
 rtl/control_buffer_pixeles.sv | 127 ++++++++++++
 3 files changed

// File: rtl/ctrl_buf_pkg.sv
// Shared encodings and constants for the pixel buffer controller.
// Imported by fetch_palabras_mem and control_buffer_pixeles.
package ctrl_buf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } main_st_t;

  typedef enum logic {
    F_IDLE = 1'b0,
    F_REQ  = 1'b1
  } fetch_st_t;

  localparam int PIX_PER_WORD = 4;
  localparam int PIX_IDX_W    = 2;

endpackage

// File: rtl/fetch_palabras_mem.sv
// Word fetcher: request FSM, address/request counters, optional timeout.
// Timeout logic is present only when CTRL_BUF_TIMEOUT_EN is defined.
module fetch_palabras_mem
  import ctrl_buf_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              load,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_words,
  input  logic              room_available,
  input  logic              mem_rd_ack,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              save_mem_data,
  output logic              timeout
);

  fetch_st_t        fstate;
  fetch_st_t        fnext;
  logic [CNT_W-1:0] words_req;
  logic [CNT_W-1:0] num_lat;
  logic             want;

  assign mem_rd_req    = (fstate == F_REQ);
  assign save_mem_data = mem_rd_req & mem_rd_ack;
  assign want          = enable && room_available &&
                         (words_req < num_lat);

`ifdef CTRL_BUF_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;

  assign timeout = mem_rd_req && !mem_rd_ack &&
                   (tcnt == TW'(TIMEOUT_CYCLES - 1));

  // Count cycles spent waiting on the current request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcnt <= '0;
    end else if (!mem_rd_req || mem_rd_ack) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout    = 1'b0;
`endif

  // Next request state: issue when room exists, retire on ack or abort.
  always_comb begin
    fnext = fstate;
    unique case (fstate)
      F_IDLE: if (want) fnext = F_REQ;
      F_REQ:  if (!enable || mem_rd_ack || timeout) fnext = F_IDLE;
      default: fnext = F_IDLE;
    endcase
  end

  // Request state, address pointer and issued-word counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fstate    <= F_IDLE;
      mem_addr  <= '0;
      words_req <= '0;
      num_lat   <= '0;
    end else begin
      fstate <= fnext;
      if (load) begin
        mem_addr  <= base_addr;
        words_req <= '0;
        num_lat   <= num_words;
      end else if (save_mem_data) begin
        mem_addr  <= mem_addr + 1'b1;
        words_req <= words_req + 1'b1;
      end
    end
  end

endmodule

// File: rtl/control_buffer_pixeles.sv
// Sequencer for buffer_pixeles_mem: prefetch words, drain 4 pixels each.
// Define CTRL_BUF_TIMEOUT_EN to enable the memory-ack timeout/error path.
module control_buffer_pixeles
  import ctrl_buf_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int CNT_W          = 16,
  parameter int DEPTH_WORDS    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_words,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rd_ack,
  output logic              save_mem_data,
  output logic              read_pixel,
  output logic              pixel_valid,
  input  logic              pixel_ready,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int OCC_W = $clog2(DEPTH_WORDS + 1);

  main_st_t             state;
  main_st_t             next;
  logic [OCC_W-1:0]     words_in_buf;
  logic [PIX_IDX_W-1:0] pix_idx;
  logic [CNT_W+1:0]     pixels_left;
  logic                 accept;
  logic                 run;
  logic                 room;
  logic                 pop_word;
  logic                 timeout;
  logic                 last_pop;

  assign accept      = start && (state == ST_IDLE);
  assign run         = (state == ST_RUN);
  assign room        = words_in_buf < OCC_W'(DEPTH_WORDS);
  assign pixel_valid = run && (words_in_buf != '0);
  assign read_pixel  = pixel_valid & pixel_ready;
  assign pop_word    = read_pixel &&
                       (pix_idx == PIX_IDX_W'(PIX_PER_WORD - 1));
  assign busy        = (state != ST_IDLE);
  assign done        = (state == ST_DONE);
  assign last_pop    = read_pixel &&
                       (pixels_left == (CNT_W+2)'(1));

  fetch_palabras_mem #(
    .ADDR_W         (ADDR_W),
    .CNT_W          (CNT_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_fetch (
    .clk            (clk),
    .reset          (reset),
    .enable         (run),
    .load           (accept),
    .base_addr      (base_addr),
    .num_words      (num_words),
    .room_available (room),
    .mem_rd_ack     (mem_rd_ack),
    .mem_rd_req     (mem_rd_req),
    .mem_addr       (mem_addr),
    .save_mem_data  (save_mem_data),
    .timeout        (timeout)
  );

  // Main sequencing: run until every pixel is taken, then a done cycle.
  always_comb begin
    next = state;
    unique case (state)
      ST_IDLE: if (start) next = ST_RUN;
      ST_RUN:  if (timeout || last_pop ||
                   pixels_left == '0) next = ST_DONE;
      ST_DONE: next = ST_IDLE;
      default: next = ST_IDLE;
    endcase
  end

  // State, occupancy, pixel index and remaining-pixel bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      words_in_buf <= '0;
      pix_idx      <= '0;
      pixels_left  <= '0;
    end else begin
      state <= next;
      if (accept) begin
        words_in_buf <= '0;
        pix_idx      <= '0;
        pixels_left  <= {num_words, 2'b00};
      end else begin
        if (save_mem_data && !pop_word) begin
          words_in_buf <= words_in_buf + 1'b1;
        end else if (pop_word && !save_mem_data) begin
          words_in_buf <= words_in_buf - 1'b1;
        end
        if (read_pixel) begin
          pix_idx     <= pix_idx + 1'b1;
          pixels_left <= pixels_left - 1'b1;
        end
      end
    end
  end

`ifdef CTRL_BUF_TIMEOUT_EN
  // Sticky abort flag, cleared by the next accepted start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      error <= 1'b0;
    end else if (accept) begin
      error <= 1'b0;
    end else if (timeout) begin
      error <= 1'b1;
    end
  end
`else
  assign error = 1'b0;
`endif

endmodule
